// File: rtl/systolic_pkg.sv
// Shared constants and sequencer state encoding for the systolic tile scheduler.
package systolic_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SWITCH,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_tile_sched_row_skew.sv
// Per-row delay line carrying {valid, switch, input} toward the array West edge.
module row_skew #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inj_valid,
  input  logic          inj_switch,
  input  logic [DW-1:0] inj_data,
  output logic          valid,
  output logic          switch,
  output logic [DW-1:0] data
);

  logic [DW+1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= {inj_valid, inj_switch, inj_data};
      for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign {valid, switch, data} = stage[DEPTH-1];

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile sequencer: weight load, settle, switch wavefront, skewed input streaming,
// and completion tracking on bottom-row psum valids.
module systolic_tile_sched #(
  parameter int unsigned N  = systolic_pkg::N,
  parameter int unsigned DW = systolic_pkg::DW,
  parameter int unsigned CW = systolic_pkg::CW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CW-1:0]        cmd_num_vec,
  input  logic [N-1:0]         cmd_col_en,
  input  logic                 cmd_reload,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [N*DW-1:0]      w_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      in_data,
  output logic [N-1:0]         arr_col_en,
  output logic [N-1:0]         arr_accept_w,
  output logic [N*DW-1:0]      arr_weight,
  output logic [$clog2(N)-1:0] arr_index,
  output logic [N-1:0]         arr_valid,
  output logic [N-1:0]         arr_switch,
  output logic [N*DW-1:0]      arr_input,
  input  logic                 arr_psum_valid_bot,
  output logic                 busy,
  output logic                 done
);

  import systolic_pkg::*;

  localparam int unsigned RW = $clog2(N);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] num_vec;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] psum_cnt;
  logic [CW:0]   psum_nxt;
  logic [RW-1:0] row_cnt;
  logic [RW-1:0] settle_cnt;
  logic          cmd_fire;
  logic          w_fire;
  logic          in_fire;
  logic          psum_inc;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign w_fire   = w_valid && w_ready;
  assign in_fire  = in_valid && in_ready;
  assign psum_inc = arr_psum_valid_bot && (state == STREAM || state == DRAIN);
  // One bit wider so a full-scale tile count cannot wrap before the compare.
  assign psum_nxt = {1'b0, psum_cnt} + (CW+1)'(psum_inc);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_reload)              state_nxt = LOAD;
          else if (cmd_num_vec == '0)  state_nxt = DONE;
          else                         state_nxt = STREAM;
        end
      end
      LOAD:    if (w_fire && row_cnt == RW'(N-1)) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == RW'(N-1))        state_nxt = SWITCH;
      SWITCH:  state_nxt = (num_vec == '0) ? DONE : STREAM;
      STREAM:  if (in_fire && vec_cnt == num_vec - 1'b1) state_nxt = DRAIN;
      DRAIN:   if (psum_nxt >= {1'b0, num_vec}) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      w_ready      <= 1'b0;
      in_ready     <= 1'b0;
      done         <= 1'b0;
      num_vec      <= '0;
      vec_cnt      <= '0;
      psum_cnt     <= '0;
      row_cnt      <= '0;
      settle_cnt   <= '0;
      arr_col_en   <= '0;
      arr_accept_w <= '0;
      arr_weight   <= '0;
      arr_index    <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      w_ready   <= (state_nxt == LOAD);
      in_ready  <= (state_nxt == STREAM);
      done      <= (state_nxt == DONE);

      arr_accept_w <= {N{w_fire}};
      arr_weight   <= w_fire ? w_data : '0;
      arr_index    <= w_fire ? row_cnt : '0;

      if (cmd_fire) begin
        num_vec    <= cmd_num_vec;
        arr_col_en <= cmd_col_en;
        vec_cnt    <= '0;
        psum_cnt   <= '0;
        row_cnt    <= '0;
        settle_cnt <= '0;
      end else begin
        psum_cnt <= psum_nxt[CW-1:0];
        if (w_fire)
          row_cnt <= (row_cnt == RW'(N-1)) ? '0 : row_cnt + 1'b1;
        if (state == SETTLE)
          settle_cnt <= (settle_cnt == RW'(N-1)) ? '0 : settle_cnt + 1'b1;
        if (in_fire)
          vec_cnt <= vec_cnt + 1'b1;
      end
    end
  end

  // Row i sees the row-0 injection delayed i further cycles.
  for (genvar i = 0; i < N; i++) begin : g_row
    row_skew #(
      .DEPTH(i + 1),
      .DW   (DW)
    ) u_skew (
      .clk       (clk),
      .rst       (rst),
      .inj_valid (in_fire),
      .inj_switch(state == SWITCH),
      .inj_data  (in_fire ? in_data[i*DW +: DW] : '0),
      .valid     (arr_valid[i]),
      .switch    (arr_switch[i]),
      .data      (arr_input[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Scoreboard bench for systolic_tile_sched: handshakes push timed expectations,
// DUT outputs pop and compare them.
`timescale 1ns/1ps
module tb_systolic_tile_sched;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_reload;
  logic [CW-1:0]     cmd_num_vec;
  logic [N-1:0]      cmd_col_en;
  logic              w_valid, w_ready;
  logic [N*DW-1:0]   w_data;
  logic              in_valid, in_ready;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      arr_col_en, arr_accept_w, arr_valid, arr_switch;
  logic [N*DW-1:0]   arr_weight, arr_input;
  logic [3:0]        arr_index;
  logic              arr_psum_valid_bot, busy, done;

  always #5 clk = ~clk;

  systolic_tile_sched #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_vec(cmd_num_vec),
    .cmd_col_en(cmd_col_en), .cmd_reload(cmd_reload),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_col_en(arr_col_en), .arr_accept_w(arr_accept_w), .arr_weight(arr_weight),
    .arr_index(arr_index), .arr_valid(arr_valid), .arr_switch(arr_switch),
    .arr_input(arr_input), .arr_psum_valid_bot(arr_psum_valid_bot),
    .busy(busy), .done(done)
  );

  typedef struct { int unsigned cyc; logic [7:0] val; } ev_t;
  typedef struct { int unsigned cyc; logic [3:0] idx; logic [N*DW-1:0] data; } wev_t;

  ev_t         q_v0[$], q_v5[$];
  wev_t        q_w[$];
  int unsigned q_s0[$], q_s15[$], q_done[$];
  ev_t         ve;
  wev_t        we;
  int unsigned ce;

  int unsigned n_cmp = 0, n_bad = 0, cyc = 0;
  bit          mon_off = 1'b0;

  // reference model of the tile in flight
  int unsigned cur_m = 0, wbeats = 0, acc = 0, npsum = 0;
  int unsigned load_start = 0, stream_start = 0, last_beat = 0, first_v0 = 0;
  bit          cur_reload = 1'b0, stream_ok = 1'b0, first_seen = 1'b0;
  bit          exp_rdy;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!mon_off && !rst) begin
      if (arr_accept_w != '0) begin
        if (q_w.size() == 0) check("w_unexp", arr_accept_w, 0);
        else begin
          we = q_w.pop_front();
          check("w_cyc", cyc, we.cyc);
          check("w_acc", arr_accept_w, {N{1'b1}});
          check("w_idx", arr_index, we.idx);
          check("w_data", arr_weight, we.data);
        end
      end else begin
        check("w_idle_data", arr_weight, 0);
        check("w_idle_idx", arr_index, 0);
      end
      if (arr_valid[0]) begin
        if (!first_seen) begin first_v0 = cyc; first_seen = 1'b1; end
        if (q_v0.size() == 0) check("v0_unexp", arr_valid[0], 0);
        else begin
          ve = q_v0.pop_front();
          check("v0_cyc", cyc, ve.cyc);
          check("v0_data", arr_input[7:0], ve.val);
        end
      end
      if (arr_valid[5]) begin
        if (q_v5.size() == 0) check("v5_unexp", arr_valid[5], 0);
        else begin
          ve = q_v5.pop_front();
          check("v5_cyc", cyc, ve.cyc);
          check("v5_data", arr_input[47:40], ve.val);
        end
      end
      if (arr_switch[0]) begin
        if (q_s0.size() == 0) check("s0_unexp", arr_switch[0], 0);
        else begin ce = q_s0.pop_front(); check("s0_cyc", cyc, ce); end
      end
      if (arr_switch[15]) begin
        if (q_s15.size() == 0) check("s15_unexp", arr_switch[15], 0);
        else begin ce = q_s15.pop_front(); check("s15_cyc", cyc, ce); end
      end
      if (done) begin
        if (q_done.size() == 0) check("done_unexp", done, 0);
        else begin ce = q_done.pop_front(); check("done_cyc", cyc, ce); end
      end

      if (cmd_valid && cmd_ready) begin
        cur_m = cmd_num_vec; cur_reload = cmd_reload;
        wbeats = 0; acc = 0; npsum = 0; first_seen = 1'b0;
        load_start = cyc + 1;
        stream_ok = !cmd_reload; stream_start = cyc + 1;
        if (!cmd_reload && cmd_num_vec == 0) q_done.push_back(cyc + 1);
      end
      if (w_valid) begin
        exp_rdy = cur_reload && wbeats < N && cyc >= load_start;
        check("w_rdy", w_ready, exp_rdy);
        if (exp_rdy) begin
          q_w.push_back('{cyc + 1, 4'(wbeats), w_data});
          wbeats++;
          if (wbeats == N) begin
            last_beat = cyc;
            q_s0.push_back(cyc + N + 2);
            q_s15.push_back(cyc + N + 17);
            stream_ok = 1'b1; stream_start = cyc + N + 2;
            if (cur_m == 0) q_done.push_back(cyc + N + 2);
          end
        end
      end
      if (in_valid) begin
        exp_rdy = stream_ok && cyc >= stream_start && acc < cur_m;
        check("in_rdy", in_ready, exp_rdy);
        if (exp_rdy) begin
          q_v0.push_back('{cyc + 1, in_data[7:0]});
          q_v5.push_back('{cyc + 6, in_data[47:40]});
          acc++;
        end
      end
      if (arr_psum_valid_bot && npsum < cur_m) begin
        npsum++;
        if (npsum == cur_m) q_done.push_back(cyc + 1);
      end
    end
  end

  function automatic logic [N*DW-1:0] rnd_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N*DW/32; i++) v[i*32 +: 32] = $urandom() | 32'h0101_0101;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input int unsigned m, input logic [N-1:0] col, input bit rl);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_num_vec = CW'(m); cmd_col_en = col; cmd_reload = rl;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); ok = cmd_ready; tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accept_to", ok, 1);
  endtask

  task automatic load_weights(input int unsigned gap);
    bit ok;
    for (int r = 0; r < N; r++) begin
      w_valid = 1'b1; w_data = rnd_vec(); ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk); ok = w_ready; tick();
      end
      check("w_beat_to", ok, 1);
      w_valid = 1'b0;
      if (r == 0 && gap > 0) begin
        w_data = rnd_vec();
        repeat (gap) tick();
      end
    end
  endtask

  task automatic run_stream(input int unsigned m, input bit gap);
    bit ok;
    for (int k = 0; k < int'(m); k++) begin
      in_valid = 1'b1; in_data = rnd_vec(); ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk); ok = in_ready; tick();
      end
      check("in_beat_to", ok, 1);
      in_valid = 1'b0;
      if (gap && k != int'(m) - 1) begin in_data = rnd_vec(); tick(); end
    end
  endtask

  task automatic drive_psums(input int unsigned m);
    repeat (2) tick();
    for (int k = 0; k < int'(m); k++) begin
      arr_psum_valid_bot = 1'b1; tick();
      arr_psum_valid_bot = 1'b0; tick();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check("idle_to", busy, 0);
    repeat (3) tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, arr_valid, 0);
    check({tag, "_switch"}, arr_switch, 0);
    check({tag, "_input"}, arr_input, 0);
    check({tag, "_acc"}, arr_accept_w, 0);
    check({tag, "_weight"}, arr_weight, 0);
    check({tag, "_index"}, arr_index, 0);
    check({tag, "_col"}, arr_col_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_rdy"}, cmd_ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_w_rdy"}, w_ready, 0);
    check({tag, "_in_rdy"}, in_ready, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_num_vec = '0; cmd_col_en = '0; cmd_reload = 1'b0;
    w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0; arr_psum_valid_bot = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_cleared("rst");
    tick(); rst = 1'b0; tick();

    // full load, switch wavefront, first valid right after switch
    send_cmd(4, '1, 1'b1);
    load_weights(0);
    run_stream(4, 1'b0);
    drive_psums(4);
    wait_idle();
    check("t1_first_valid", first_v0, last_beat + N + 3);

    // no reload, bubbles between vectors
    send_cmd(3, '1, 1'b0);
    run_stream(3, 1'b1);
    drive_psums(3);
    wait_idle();

    // reload with empty tile: done right after the switch, inputs refused
    send_cmd(0, '1, 1'b1);
    load_weights(0);
    in_valid = 1'b1; in_data = rnd_vec();
    wait_idle();
    in_valid = 1'b0;

    // gaps in the weight stream
    send_cmd(2, '1, 1'b1);
    load_weights(2);
    run_stream(2, 1'b1);
    drive_psums(2);
    wait_idle();

    // reset in the middle of streaming
    send_cmd(4, '1, 1'b0);
    run_stream(2, 1'b0);
    mon_off = 1'b1; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check_cleared("t5");
    q_v0.delete(); q_v5.delete(); q_w.delete(); q_s0.delete(); q_s15.delete(); q_done.delete();
    cur_m = 0; cur_reload = 1'b0; wbeats = 0; acc = 0; npsum = 0; stream_ok = 1'b0;
    tick(); mon_off = 1'b0;
    repeat (5) tick();
    send_cmd(2, '1, 1'b1);
    load_weights(0);
    run_stream(2, 1'b0);
    drive_psums(2);
    wait_idle();

    // command held while busy
    send_cmd(2, '1, 1'b0);
    fork
      begin run_stream(2, 1'b0); drive_psums(2); end
      send_cmd(1, 16'h00FF, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t6_cmd_rdy", cmd_ready, 0);
          check("t6_col_hold", arr_col_en, 16'hFFFF);
        end
      end
    join
    @(negedge clk);
    check("t6_col_new", arr_col_en, 16'h00FF);
    tick();
    run_stream(1, 1'b0);
    drive_psums(1);
    wait_idle();

    check("q_left", q_v0.size() + q_v5.size() + q_w.size() + q_s0.size() + q_s15.size() + q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sched.md
Name: systolic_tile_sched

Overview:
Tile-level sequencer for the 16x16 int8 systolic array.
- Accepts one tile command and streams weight rows from a weight stream into the column tops (accept_w + index protocol).
- Waits for the weights to land, issues the per-row switch wavefront, then streams input vectors into the row West edges with per-row skew.
- Counts bottom-row psum valids to signal completion.
- Sits between the command/buffer front-end and the array top-level.

Parameters:
N, 16, array width (rows = columns)
DW, 8, int8 operand width
CW, 16, vector-count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  tile command valid
cmd_ready  out  1  high only in IDLE
cmd_num_vec  in  CW  M = input vectors in tile
cmd_col_en  in  N  column enable mask
cmd_reload  in  1  1 = load new weights before streaming
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted
w_data  in  N*DW  one array row of weights (element j -> column j); beats arrive in row order 0..N-1
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted
in_data  in  N*DW  one input vector (element i -> row i)
arr_col_en  out  N  latched column enables
arr_accept_w  out  N  per-column weight-stream valid (all equal)
arr_weight  out  N*DW  per-column weight
arr_index  out  $clog2(N)  target row index, shared by all columns
arr_valid  out  N  per-row valid, skewed
arr_switch  out  N  per-row switch, skewed
arr_input  out  N*DW  per-row input, skewed
arr_psum_valid_bot  in  1  psum valid from bottom of column 0
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset: every output = 0 except cmd_ready = 1; state IDLE; all counters and skew stages cleared.
- Reset mid-operation aborts the tile: no done pulse, skew lines flushed.
- States and transitions:
  - IDLE: on cmd_valid, latch M, col_en and reload; go to LOAD if reload = 1, else STREAM.
  - LOAD:
    - w_ready = 1.
    - Each w_valid&w_ready beat drives, registered one cycle later: arr_accept_w = all 1s, arr_weight = w_data, arr_index = row counter r.
    - r increments per beat; cycles with no beat drive accept_w = 0 and weight/index = 0.
    - After beat r = N-1, go to SETTLE.
  - SETTLE: wait exactly N cycles (lets the last row land), then go to SWITCH.
  - SWITCH:
    - One cycle; inject switch = 1, valid = 0 into the skew stage of row 0.
    - Go to STREAM, or to DONE if M = 0.
    - The switch therefore precedes the first valid at every PE by at least 1 cycle.
  - STREAM:
    - in_ready = 1.
    - Each handshake injects valid = 1 with in_data into the row-0 stage; no handshake injects a bubble (valid = 0, input = 0).
    - After M accepted vectors, go to DRAIN. With M = 0 and reload = 0, go directly to DONE.
  - DRAIN: wait until the psum-valid count reaches M, then go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- Skew: row i's valid/switch/input are the row-0 injection delayed by i cycles (row 0 = 1 register stage, row N-1 = N stages).
- psum counter:
  - Counts arr_psum_valid_bot only in STREAM and DRAIN; cleared on command accept.
  - A valid arriving in the same cycle the STREAM→DRAIN transition happens is counted.
- Column enables: arr_col_en updates only on command accept and is held for the whole tile.
- Stream gating: w_ready = 0 outside LOAD; in_ready = 0 outside STREAM.
- Widths and wrap:
  - Row counter is $clog2(N) bits and reaches N-1 without wrap.
  - Vector counters are CW bits; M = 2^CW-1 is supported.
- Simultaneous events: a cmd_valid seen while busy is ignored (cmd_ready = 0), and the command must be held until accepted.

Decomposition:
- Shared package systolic_pkg holds:
  - N, DW, CW and IW = $clog2(N)
  - the state enum {IDLE, LOAD, SETTLE, SWITCH, STREAM, DRAIN, DONE}
- One sub-module, row_skew: parameterised per-row delay line carrying {valid, switch, input[DW]}.
  - Instanced N times with depth i+1.
  - Synchronous reset clears every stage.

Test Plan:
1. reload = 1, M = 4, col_en = all ones, 16 back-to-back weight beats:
   - arr_index counts 0..15 on consecutive cycles with accept_w all ones.
   - After the last beat: 16 SETTLE cycles, then arr_switch[0] pulses, arr_switch[15] 15 cycles later.
   - arr_valid[0] rises the cycle after arr_switch[0].
2. reload = 0, M = 3, in_valid toggling 1,0,1,0,1:
   - arr_valid[0] pattern 1,0,1,0,1.
   - arr_valid[5] is the same pattern delayed 5 cycles.
   - done pulses one cycle after the 3rd bottom psum valid.
3. reload = 1, M = 0:
   - Full load, SETTLE and SWITCH occur; no arr_valid is ever asserted.
   - done pulses the cycle after SWITCH.
4. w_valid gaps (beats at cycles 0, 3, 4):
   - arr_accept_w = 0 with weight/index = 0 in the gap cycles.
   - Index sequence is unchanged: 0, 1, 2.
5. rst asserted mid-STREAM:
   - Next cycle all arr_* are 0, busy = 0, cmd_ready = 1, and done is never asserted.
   - A new command after that completes normally.
6. cmd_valid held while busy, with col_en changed to 0x00FF:
   - cmd_ready = 0 and arr_col_en stays at its latched value.
   - After done, the command is accepted and arr_col_en = 0x00FF.
